// File: rtl/gpu_cmd_pkg.sv
// Command-word field layout, opcodes, FIFO word format and sequencer states
// shared by the command fetch path.
package gpu_cmd_pkg;

  localparam int HDR_PAY_BIT = 31;
  localparam int HDR_CNT_MSB = 15;
  localparam int HDR_CNT_LSB = 8;
  localparam int HDR_OP_MSB  = 7;
  localparam int HDR_OP_LSB  = 0;

  localparam logic [7:0] OP_VERTEX      = 8'h03;
  localparam logic [7:0] OP_COLOR       = 8'h04;
  localparam logic [7:0] OP_MATRIX_MODE = 8'h10;
  localparam logic [7:0] OP_LOAD_MATRIX = 8'h13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_ERR
  } seq_state_e;

  typedef struct packed {
    logic        is_hdr;
    logic        last;
    logic [7:0]  opcode;
    logic [31:0] data;
  } cmd_word_t;

endpackage

// File: rtl/cmd_out_fifo.sv
// Small synchronous FIFO buffering classified command words toward the
// geometry front end; reports occupancy so the fetcher can throttle reads.
module cmd_out_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 42
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // NOTE: storage has no reset; pop_data is masked while empty so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cmd_fetch_sequencer.sv
// Streams command words from base_addr to end_addr, tagging headers/payload.
// Optional header/truncation checking is enabled by defining CMD_ERR_CHECK_EN.
module cmd_fetch_sequencer
  import gpu_cmd_pkg::*;
#(
  parameter int AW       = 32,
  parameter int FIFO_DEP = 2,
  parameter int MAX_PAY  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] end_addr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_is_hdr,
  output logic [7:0]    out_opcode,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int WAW = AW - 2;
  localparam int CW  = $clog2(FIFO_DEP + 1);

  if (FIFO_DEP < 2 || MAX_PAY < 1 || MAX_PAY > 255) begin : g_bad_cfg
    $error("cmd_fetch_sequencer: FIFO_DEP must be >= 2 and MAX_PAY within 1..255");
  end

  seq_state_e     state_q, state_d;
  logic [WAW-1:0] addr_q, end_q, base_w, end_w;
  logic           inflight_q, busy_q, done_q;
  logic [7:0]     pay_rem_q, pay_rem_d, opcode_q, opcode_d;
  logic [7:0]     ret_cnt, ret_op;
  logic           ret_hdr, ret_has_pay, bad_hdr, push;
  logic           start_ok, empty_range, drained, finish, room;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    occupancy;
  logic           fifo_full, fifo_empty;
  cmd_word_t      push_word, pop_word;
  logic           unused_addr_bits;

  assign base_w           = base_addr[AW-1:2];
  assign end_w            = end_addr[AW-1:2];
  assign unused_addr_bits = ^{base_addr[1:0], end_addr[1:0]};
  assign start_ok         = start && (state_q == ST_IDLE);
  assign empty_range      = (base_w >= end_w);
  assign drained          = !inflight_q && fifo_empty;
  assign finish           = drained && (state_q == ST_DRAIN || state_q == ST_ERR);

  // Count words already reserved (buffered or still in the memory pipe) so a stall never overflows.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign room      = !fifo_full && (occupancy < (CW+1)'(FIFO_DEP));

  assign ret_cnt     = mem_rdata[HDR_CNT_MSB:HDR_CNT_LSB];
  assign ret_op      = mem_rdata[HDR_OP_MSB:HDR_OP_LSB];
  assign ret_hdr     = (pay_rem_q == '0);
  assign ret_has_pay = mem_rdata[HDR_PAY_BIT] && (ret_cnt != '0);

`ifdef CMD_ERR_CHECK_EN
  assign bad_hdr = inflight_q && ret_hdr && ret_has_pay && (ret_cnt > 8'(MAX_PAY));
`else
  assign bad_hdr = 1'b0;
`endif

  assign push = inflight_q && !bad_hdr && (state_q != ST_ERR);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    pay_rem_d        = pay_rem_q;
    opcode_d         = opcode_q;
    push_word.is_hdr = ret_hdr;
    push_word.data   = mem_rdata;
    push_word.opcode = ret_hdr ? ret_op : opcode_q;
    push_word.last   = ret_hdr ? !ret_has_pay : (pay_rem_q == 8'd1);
    if (start_ok) begin
      pay_rem_d = '0;
    end else if (inflight_q) begin
      if (ret_hdr) begin
        pay_rem_d = ret_has_pay ? ret_cnt : 8'd0;
        opcode_d  = ret_op;
      end else begin
        pay_rem_d = pay_rem_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (empty_range || (base_w + WAW'(1) == end_w)) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bad_hdr) state_d = ST_ERR;
        else if (mem_rd && (addr_q + WAW'(1) == end_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bad_hdr)      state_d = ST_ERR;
        else if (drained) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (drained) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The first read issues straight from IDLE so data returns the cycle after start.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = {addr_q, 2'b00};
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !empty_range) begin
            mem_rd   = 1'b1;
            mem_addr = {base_w, 2'b00};
          end
        end
        ST_FETCH: mem_rd = room && !bad_hdr;
        default:  mem_rd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      end_q      <= '0;
      inflight_q <= 1'b0;
      pay_rem_q  <= '0;
      opcode_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= mem_rd;
      pay_rem_q  <= pay_rem_d;
      opcode_q   <= opcode_d;
      done_q     <= finish;
      if (mem_rd) addr_q <= mem_addr[AW-1:2] + WAW'(1);
      if (start_ok) begin
        end_q  <= end_w;
        busy_q <= 1'b1;
      end else if (finish) begin
        busy_q <= 1'b0;
      end
    end
  end

`ifdef CMD_ERR_CHECK_EN
  logic error_q;
  always_ff @(posedge clk) begin
    if (rst || start_ok) error_q <= 1'b0;
    else if (bad_hdr || (finish && state_q == ST_DRAIN && pay_rem_q != '0)) error_q <= 1'b1;
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  cmd_out_fifo #(
    .DEPTH (FIFO_DEP),
    .WIDTH ($bits(cmd_word_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (out_ready),
    .pop_data  (pop_word),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = pop_word.data;
  assign out_is_hdr = pop_word.is_hdr;
  assign out_opcode = pop_word.opcode;
  assign out_last   = pop_word.last;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cmd_fetch_sequencer.sv
// Directed self-checking bench for cmd_fetch_sequencer with a 1-cycle-latency memory model.
module tb_cmd_fetch_sequencer;
  import gpu_cmd_pkg::*;

`ifdef CMD_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [31:0] base_addr, end_addr, mem_addr, mem_rdata, out_data;
  logic        mem_rd, out_valid, out_is_hdr, out_last, busy, done, error;
  logic [7:0]  out_opcode;

  always #5 clk = ~clk;

  cmd_fetch_sequencer #(.AW(32), .FIFO_DEP(2), .MAX_PAY(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .end_addr(end_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_hdr(out_is_hdr), .out_opcode(out_opcode), .out_last(out_last),
    .busy(busy), .done(done), .error(error)
  );

  logic [31:0] mem [64];
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;

  logic [31:0] got_d[$], rd_addrs[$], exp_d[$];
  logic        got_h[$], got_l[$], exp_h[$], exp_l[$];
  logic [7:0]  got_o[$], exp_o[$];
  int mon_rd, mon_pop, mon_done, mon_valid, mon_viol;

  always @(negedge clk) begin
    if (mem_rd) begin
      if (mon_rd - mon_pop >= 2) mon_viol++;
      rd_addrs.push_back(mem_addr);
      mon_rd++;
    end
    if (out_valid && out_ready) begin
      got_d.push_back(out_data); got_h.push_back(out_is_hdr);
      got_l.push_back(out_last); got_o.push_back(out_opcode);
      mon_pop++;
    end
    if (out_valid) mon_valid++;
    if (done) mon_done++;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    got_d.delete(); got_h.delete(); got_l.delete(); got_o.delete(); rd_addrs.delete();
    exp_d.delete(); exp_h.delete(); exp_l.delete(); exp_o.delete();
    mon_rd = 0; mon_pop = 0; mon_done = 0; mon_valid = 0; mon_viol = 0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic h, input logic l, input logic [7:0] o);
    exp_d.push_back(d); exp_h.push_back(h); exp_l.push_back(l); exp_o.push_back(o);
  endtask

  task automatic launch(input logic [31:0] b, input logic [31:0] e);
    base_addr = b; end_addr = e; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rand_ready);
    int i;
    i = 0;
    while (mon_done == 0 && i < budget) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    out_ready = 1'b1;
    repeat (4) tick();
    check({tag, "_done_once"}, 32'(mon_done), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, 32'(got_d.size()), 32'(exp_d.size()));
    foreach (exp_d[i]) begin
      if (i < got_d.size()) begin
        check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
        check($sformatf("%s_hdr%0d", tag, i), 32'(got_h[i]), 32'(exp_h[i]));
        check($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
        check($sformatf("%s_op%0d", tag, i), 32'(got_o[i]), 32'(exp_o[i]));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0; end_addr = '0;
    foreach (mem[i]) mem[i] = '0;
    clear_mon();
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    tick();

    // Mixed headers: two immediates, then a 3-word colour payload.
    mem[0] = 32'h0000_0010; mem[1] = 32'h0000_0110; mem[2] = 32'h8000_0304;
    mem[3] = 32'h3F80_0000; mem[4] = 32'h3F00_0000; mem[5] = 32'h0000_0000;
    clear_mon();
    expect_word(32'h0000_0010, 1, 1, OP_MATRIX_MODE);
    expect_word(32'h0000_0110, 1, 1, OP_MATRIX_MODE);
    expect_word(32'h8000_0304, 1, 0, OP_COLOR);
    expect_word(32'h3F80_0000, 0, 0, OP_COLOR);
    expect_word(32'h3F00_0000, 0, 0, OP_COLOR);
    expect_word(32'h0000_0000, 0, 1, OP_COLOR);
    launch(32'h0, 32'h18);
    check("lat_cycle1_valid", 32'(out_valid), 0);
    check("lat_busy", 32'(busy), 1);
    tick();
    check("lat_cycle2_valid", 32'(out_valid), 1);
    wait_done("mix", 200, 1'b0);
    compare_stream("mix");
    check("mix_reads", 32'(rd_addrs.size()), 6);
    foreach (rd_addrs[i]) check($sformatf("mix_addr%0d", i), rd_addrs[i], 32'(4 * i));
    check("mix_error", 32'(error), 0);

    // Load-matrix with 16 floats under random backpressure.
    mem[0] = 32'h8000_1013;
    for (int i = 1; i <= 16; i++) mem[i] = 32'h4000_0000 + 32'(i);
    clear_mon();
    expect_word(32'h8000_1013, 1, 0, OP_LOAD_MATRIX);
    for (int i = 1; i <= 16; i++) expect_word(32'h4000_0000 + 32'(i), 0, (i == 16), OP_LOAD_MATRIX);
    launch(32'h0, 32'h44);
    wait_done("mtx", 2000, 1'b1);
    compare_stream("mtx");
    check("mtx_reads", 32'(mon_rd), 17);
    check("mtx_occupancy_violations", 32'(mon_viol), 0);

    // Empty range: nothing fetched, done one cycle after entering DRAIN.
    clear_mon();
    launch(32'h40, 32'h40);
    check("empty_done_early", 32'(done), 0);
    check("empty_busy", 32'(busy), 1);
    tick();
    check("empty_done", 32'(done), 1);
    tick();
    check("empty_done_fall", 32'(done), 0);
    check("empty_busy_fall", 32'(busy), 0);
    check("empty_reads", 32'(mon_rd), 0);
    check("empty_valid", 32'(mon_valid), 0);

    // Single-word range.
    mem[16] = 32'h0000_0203;
    clear_mon();
    expect_word(32'h0000_0203, 1, 1, OP_VERTEX);
    launch(32'h40, 32'h44);
    wait_done("one", 50, 1'b0);
    compare_stream("one");

    // Truncated payload: end arrives with one payload word outstanding.
    mem[0] = 32'h8000_0304; mem[1] = 32'h1111_1111; mem[2] = 32'h2222_2222;
    clear_mon();
    expect_word(32'h8000_0304, 1, 0, OP_COLOR);
    expect_word(32'h1111_1111, 0, 0, OP_COLOR);
    expect_word(32'h2222_2222, 0, 0, OP_COLOR);
    launch(32'h0, 32'h0C);
    wait_done("trunc", 100, 1'b0);
    compare_stream("trunc");
    check("trunc_error", 32'(error), 32'(ERR_EN));

`ifdef CMD_ERR_CHECK_EN
    // Oversized payload count: nothing from that header onward is delivered.
    mem[0] = 32'h0000_0110; mem[1] = 32'h8000_1113;
    for (int i = 2; i < 8; i++) mem[i] = 32'h5000_0000 + 32'(i);
    clear_mon();
    expect_word(32'h0000_0110, 1, 1, OP_MATRIX_MODE);
    launch(32'h0, 32'h20);
    wait_done("bad", 100, 1'b0);
    compare_stream("bad");
    check("bad_error", 32'(error), 1);
`endif

    // Reset mid-payload with the consumer stalled, then replay from base.
    mem[0] = 32'h8000_0304; mem[1] = 32'hAAAA_0001; mem[2] = 32'hAAAA_0002; mem[3] = 32'hAAAA_0003;
    clear_mon();
    out_ready = 1'b0;
    launch(32'h0, 32'h10);
    repeat (3) tick();
    check("rstmid_pre_valid", 32'(out_valid), 1);
    check("rstmid_occupancy_violations", 32'(mon_viol), 0);
    rst = 1'b1;
    tick();
    check("rstmid_valid", 32'(out_valid), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_mem_rd", 32'(mem_rd), 0);
    rst = 1'b0;
    tick();
    clear_mon();
    out_ready = 1'b1;
    expect_word(32'h8000_0304, 1, 0, OP_COLOR);
    expect_word(32'hAAAA_0001, 0, 0, OP_COLOR);
    expect_word(32'hAAAA_0002, 0, 0, OP_COLOR);
    expect_word(32'hAAAA_0003, 0, 1, OP_COLOR);
    launch(32'h0, 32'h10);
    wait_done("replay", 100, 1'b0);
    compare_stream("replay");
    check("replay_error", 32'(error), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
